regf_writeback: RTL
===================

// Module: regf_writeback
// PURPOSE
//  Writer side of the regf write port (w_enable/w_addr/w_data).
//  Collects results from two producers: the execute stage and the load unit.
//  Buffers and arbitrates them, then issues at most one register write per cycle.
//  Exports a pending-destination mask so issue logic can stall on RAW hazards.
// PARAMETERS
//  LD_DEPTH      4   load-result FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8   consecutive lost arbitrations before the ex entry is forced to win
// PORTS
//  clk         in   1   clock
//  rstn        in   1   async active-low reset
//  ex_valid    in   1   execute result valid
//  ex_ready    out  1   execute result accepted when ex_valid&&ex_ready
//  ex_rd       in   5   execute destination register
//  ex_data     in   32  execute result
//  ld_valid    in   1   load result valid
//  ld_ready    out  1   load result accepted when ld_valid&&ld_ready
//  ld_rd       in   5   load destination register
//  ld_data     in   32  load result
//  w_enable    out  1   to regf w_enable
//  w_addr      out  5   to regf w_addr
//  w_data      out  32  to regf w_data
//  pending     out  32  bit i=1: a write to x[i] is buffered or on the port
//  byp_rs1/2   in   5   bypass query addresses (WB_BYPASS_EN only)
//  byp_hit1/2  out  1   query matches the write port (WB_BYPASS_EN only)
//  byp_data1/2 out  32  bypass value (WB_BYPASS_EN only)
// BEHAVIOUR
//  Reset (rstn=0, async):
//   - Load FIFO and ex skid are emptied; starve counter is cleared.
//   - w_enable=0, w_addr=0, w_data=0, pending=0.
//   - ex_ready=1 and ld_ready=1 after reset release.
//   - Mid-operation reset discards all buffered writes; none reach regf.
//  Ex path:
//   - 1-entry skid register; ex_ready = !ex_full (registered state only, no same-cycle pass-through).
//  Load path:
//   - LD_DEPTH FIFO, in-order; ld_ready = !full.
//   - Push and pop in the same cycle are legal.
//   - Pointers are log2(LD_DEPTH)+1 bits and wrap; full/empty come from the MSB compare.
//  Arbitration (combinational, every cycle):
//   - sel_ex = ex_full && (ld_empty || starve_cnt==STARVE_LIMIT).
//   - Otherwise the FIFO head pops if non-empty.
//   - starve_cnt increments when ex_full && !sel_ex.
//   - starve_cnt clears when sel_ex or !ex_full; it saturates at STARVE_LIMIT.
//  Output register (updated at every edge):
//   - w_enable = winner exists && winner.rd!=0.
//   - w_addr/w_data take winner's rd/data; otherwise w_enable=0 and addr/data hold.
//   - rd==0 entries are consumed with w_enable=0.
//  Latency:
//   - An entry accepted at edge E, into empty buffers with no contention, drives w_enable=1 from edge E+1 to E+2.
//   - regf commits it at edge E+2.
//  pending:
//   - Combinational OR over all valid FIFO entries, the ex skid, and the output register (when w_enable).
//   - Bit 0 is forced to 0.
//  Ordering:
//   - No ordering is guaranteed between ex and ld results to the same rd.
//   - Issue logic must stall on pending[rd].
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   - byp_* ports exist.
//   - byp_hitN = w_enable && w_addr==byp_rsN && byp_rsN!=0; byp_dataN = w_data (combinational).
//   - This covers the write-then-read edge that regf's registered read misses.
//  WB_BYPASS_EN undefined:
//   - byp_* ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package regf_wb_pkg:
//   - typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_entry_t
//   - localparam REG_W=32, REG_N=32.
//  Sub-module regf_wb_fifo:
//   - Parameterised by depth; payload wb_entry_t.
//   - Exposes valid-entry rd list for pending generation.
// TESTING
//  1. Assert reset -> all outputs 0; ex_ready=1, ld_ready=1, pending=0 after release.
//  2. ex rd=5, data=0xDEADBEEF, one cycle -> w_enable=1, w_addr=5, w_data=0xDEADBEEF for exactly one cycle.
//     pending[5]=1 from E until the w_enable cycle ends.
//  3. ld rd=3 and ex rd=4 at the same edge -> x3 write cycle first, x4 write the following cycle.
//  4. 5 back-to-back loads plus a continuous load stream, ex rd=7 held in skid:
//     - ld_ready=0 while the FIFO holds 4 entries;
//     - ex loses 8 arbitrations, then x7 is written on the 9th.
//  5. ex rd=0, data=0x1 -> ex_ready recovers, w_enable stays 0, pending stays 0.
//     Drop rstn with 3 FIFO entries buffered -> no w_enable after release, pending=0.
//  6. WB_BYPASS_EN: byp_rs1=9 while the x9 write is on the port -> byp_hit1=1, byp_data1=w_data.
//     byp_rs1=0 -> byp_hit1=0.

Source files
------------

// File: rtl/regf_wb_pkg.sv
// Shared types and constants for the regf writeback block.
// The optional bypass ports are enabled by WB_BYPASS_EN in regf_writeback.
package regf_wb_pkg;

  localparam int REG_W = 32;
  localparam int REG_N = 32;

  typedef struct packed {
    logic [4:0]       rd;
    logic [REG_W-1:0] data;
  } wb_entry_t;

  function automatic logic [REG_N-1:0] rd_onehot(input logic [4:0] rd);
    logic [REG_N-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regf_wb_fifo.sv
// In-order load-result FIFO with wrap-bit pointers.
// Also exports every slot's rd together with a valid mask so that pending can be built.
module regf_wb_fifo
  import regf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      valid_mask,
  output logic [DEPTH-1:0][4:0] rd_list
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] off;
    off        = '0;
    valid_mask = '0;
    rd_list    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = AW'(i) - rd_ptr[AW-1:0];
      valid_mask[i] = ({1'b0, off} < count);
      rd_list[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/regf_writeback.sv
// Writeback arbiter: execute skid + load FIFO feeding one registered regf write port.
// Define WB_BYPASS_EN to add the byp_* forwarding ports.
module regf_writeback
  import regf_wb_pkg::*;
#(
  parameter int LD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [4:0]       ex_rd,
  input  logic [REG_W-1:0] ex_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [REG_W-1:0] ld_data,
  output logic             w_enable,
  output logic [4:0]       w_addr,
  output logic [REG_W-1:0] w_data,
  output logic [REG_N-1:0] pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]       byp_rs1,
  input  logic [4:0]       byp_rs2,
  output logic             byp_hit1,
  output logic             byp_hit2,
  output logic [REG_W-1:0] byp_data1,
  output logic [REG_W-1:0] byp_data2
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Handshake: a producer transfers on a cycle where valid && ready at the rising edge;
  // ready depends only on registered state, never on the same-cycle valid.
  logic                   ex_full;
  wb_entry_t              ex_entry;
  logic                   ex_push;
  logic                   ld_full;
  logic                   ld_empty;
  logic                   ld_push;
  logic                   ld_pop;
  wb_entry_t              ld_head;
  wb_entry_t              ld_in;
  logic [LD_DEPTH-1:0]    ld_valid_mask;
  logic [LD_DEPTH-1:0][4:0] ld_rd_list;
  logic [SW-1:0]          starve_cnt;
  logic                   starved;
  logic                   sel_ex;
  logic                   win_valid;
  wb_entry_t              win;

  assign ex_ready = !ex_full;
  assign ex_push  = ex_valid && !ex_full;
  assign ld_ready = !ld_full;
  assign ld_push  = ld_valid && !ld_full;
  assign ld_in    = '{rd: ld_rd, data: ld_data};

  regf_wb_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (ld_push),
    .push_entry (ld_in),
    .pop        (ld_pop),
    .head       (ld_head),
    .full       (ld_full),
    .empty      (ld_empty),
    .valid_mask (ld_valid_mask),
    .rd_list    (ld_rd_list)
  );

  // Loads win by default; the ex entry wins only when loads are idle or it has starved.
  assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
  assign sel_ex    = ex_full && (ld_empty || starved);
  assign ld_pop    = !sel_ex && !ld_empty;
  assign win_valid = sel_ex || ld_pop;
  assign win       = sel_ex ? ex_entry : ld_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_full  <= 1'b0;
      ex_entry <= '0;
    end else if (ex_push) begin
      ex_full  <= 1'b1;
      ex_entry <= '{rd: ex_rd, data: ex_data};
    end else if (sel_ex) begin
      ex_full  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!ex_full || sel_ex) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Entries for x0 are still consumed, but never raise w_enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_enable <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
    end else if (win_valid) begin
      w_enable <= (win.rd != 5'd0);
      w_addr   <= win.rd;
      w_data   <= win.data;
    end else begin
      w_enable <= 1'b0;
    end
  end

  always_comb begin
    logic [REG_N-1:0] p;
    p = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (ld_valid_mask[i]) p = p | rd_onehot(ld_rd_list[i]);
    end
    if (ex_full)  p = p | rd_onehot(ex_entry.rd);
    if (w_enable) p = p | rd_onehot(w_addr);
    p[0]    = 1'b0;
    pending = p;
  end

`ifdef WB_BYPASS_EN
  assign byp_hit1  = w_enable && (w_addr == byp_rs1) && (byp_rs1 != 5'd0);
  assign byp_hit2  = w_enable && (w_addr == byp_rs2) && (byp_rs2 != 5'd0);
  assign byp_data1 = w_data;
  assign byp_data2 = w_data;
`endif

endmodule
